// File: rtl/arb_rr_2x1_if.sv
`timescale 1ns/1ps
// arb_rr_2x1_if: request/response bundle for the two-source round-robin arbiter.
// Signal names are taken from the arbiter's point of view; slave is the arbiter side.
interface arb_rr_2x1_if #(
  parameter int DATA_W = 8
);
  logic [1:0]          req_valid_in;
  logic [2*DATA_W-1:0] req_data_in;
  logic [1:0]          req_last_in;
  logic [1:0]          req_ready_out;
  logic                out_valid_out;
  logic [DATA_W-1:0]   out_data_out;
  logic                out_last_out;
  logic                sel_out;
  logic                out_ready_in;
  // Observation of the round-robin pointer and packet-lock state.
  logic                dbg_prio;
  logic                dbg_locked;

  modport slave (
    input  req_valid_in, req_data_in, req_last_in, out_ready_in,
    output req_ready_out, out_valid_out, out_data_out, out_last_out, sel_out,
           dbg_prio, dbg_locked
  );

  modport master (
    output req_valid_in, req_data_in, req_last_in, out_ready_in,
    input  req_ready_out, out_valid_out, out_data_out, out_last_out, sel_out,
           dbg_prio, dbg_locked
  );
endinterface

// File: rtl/arb_rr_2x1.sv
`timescale 1ns/1ps
// arb_rr_2x1: two-source round-robin arbiter feeding a one-entry registered output stage.
// Optional packet locking is enabled by defining ARB_RR_2X1_PKT_LOCK_EN.
module arb_rr_2x1 #(
  parameter int DATA_W = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  arb_rr_2x1_if.slave bus
);

  // Handshake: a beat moves on any rising edge where valid and ready are both high;
  // valid never depends on ready, ready may depend on valid.
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              sel_q;
  logic              prio_q;

  logic       load;
  logic [1:0] cand;
  logic       grant_valid;
  logic       grant;
  logic       accept;
  logic       release_beat;

`ifdef ARB_RR_2X1_PKT_LOCK_EN
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
  state_t state_q;
  logic   lock_src_q;

  always_comb begin
    cand = bus.req_valid_in;
    if (state_q == LOCKED) cand = bus.req_valid_in & (lock_src_q ? 2'b10 : 2'b01);
  end

  // Arbitration is released only at the end of a packet.
  assign release_beat   = accept && bus.req_last_in[grant];
  assign bus.dbg_locked = (state_q == LOCKED);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      lock_src_q <= 1'b0;
    end else if (accept) begin
      if (bus.req_last_in[grant]) begin
        state_q <= IDLE;
      end else begin
        state_q    <= LOCKED;
        lock_src_q <= grant;
      end
    end
  end
`else
  assign cand           = bus.req_valid_in;
  assign release_beat   = accept;
  assign bus.dbg_locked = 1'b0;
`endif

  assign load        = !out_valid_q || bus.out_ready_in;
  assign grant_valid = |cand;
  assign grant       = (cand == 2'b11) ? prio_q : cand[1];
  assign accept      = load && grant_valid;

  // Timing note: out_ready_in reaches req_ready_out through this logic with no register.
  assign bus.req_ready_out = (rst_n_in && accept) ? (grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sel_q       <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant ? bus.req_data_in[2*DATA_W-1:DATA_W] : bus.req_data_in[DATA_W-1:0];
        out_last_q  <= bus.req_last_in[grant];
        sel_q       <= grant;
      end else if (load) begin
        out_valid_q <= 1'b0;
      end
      if (release_beat) prio_q <= !grant;
    end
  end

  assign bus.out_valid_out = out_valid_q;
  assign bus.out_data_out  = out_data_q;
  assign bus.out_last_out  = out_last_q;
  assign bus.sel_out       = sel_q;
  assign bus.dbg_prio      = prio_q;

endmodule

// File: tb/tb_arb_rr_2x1.sv
`timescale 1ns/1ps
// tb_arb_rr_2x1: queue-driven sources, a reference arbitration model and a decoupled
// output monitor for arb_rr_2x1 (honours ARB_RR_2X1_PKT_LOCK_EN when defined).
module tb_arb_rr_2x1;
  localparam int DATA_W = 8;
  localparam int W      = DATA_W + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_rr_2x1_if #(.DATA_W(DATA_W)) bus();
  arb_rr_2x1 #(.DATA_W(DATA_W)) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));

  int check_cnt = 0;
  int pass_cnt  = 0;
  // Expected held beats: {sel, last, data}.
  logic [W-1:0]      exp_q[$];
  // Pending source beats: {last, data}.
  logic [DATA_W:0]   src_q0[$];
  logic [DATA_W:0]   src_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: decides each cycle which source the spec's rules admit.
  initial begin : model
    int         prio_m;
    int         lock_m;
    int         g;
    logic       ev;
    logic       esel;
    logic       ld;
    logic [1:0] v;
    logic [1:0] er;
    logic [DATA_W-1:0] bd;
    prio_m = 0; lock_m = -1; ev = 1'b0; esel = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prio_m = 0; lock_m = -1; ev = 1'b0; esel = 1'b0;
      end else begin
        v = bus.req_valid_in;
        check("out_valid", 32'(bus.out_valid_out), 32'(ev));
        check("sel_out", 32'(bus.sel_out), 32'(esel));
        check("prio", 32'(bus.dbg_prio), 32'(prio_m));
        check("locked", 32'(bus.dbg_locked), 32'(lock_m >= 0));
        ld = !ev || bus.out_ready_in;
        g  = -1;
        if (ld) begin
          if (lock_m >= 0) begin
            if (v[lock_m]) g = lock_m;
          end else if (v == 2'b11) g = prio_m;
          else if (v[0]) g = 0;
          else if (v[1]) g = 1;
        end
        er = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        check("req_ready", 32'(bus.req_ready_out), 32'(er));
        if (g >= 0) begin
          bd = (g == 0) ? bus.req_data_in[DATA_W-1:0] : bus.req_data_in[2*DATA_W-1:DATA_W];
          exp_q.push_back({g[0], bus.req_last_in[g], bd});
          ev   = 1'b1;
          esel = g[0];
`ifdef ARB_RR_2X1_PKT_LOCK_EN
          if (bus.req_last_in[g]) begin
            prio_m = 1 - g;
            lock_m = -1;
          end else begin
            lock_m = g;
          end
`else
          prio_m = 1 - g;
`endif
        end else if (ld) begin
          ev = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every presented beat with the queue head, pops on transfer.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.out_valid_out) begin
        if (exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t",
                   {bus.sel_out, bus.out_last_out, bus.out_data_out}, $time);
        end else begin
          check("out_beat", 32'({bus.sel_out, bus.out_last_out, bus.out_data_out}), 32'(exp_q[0]));
          if (bus.out_ready_in) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cycle(input logic [1:0] en, input logic rdy);
    logic [1:0]      acc;
    logic [DATA_W:0] h0;
    logic [DATA_W:0] h1;
    h0 = (src_q0.size() != 0) ? src_q0[0] : '0;
    h1 = (src_q1.size() != 0) ? src_q1[0] : '0;
    bus.req_valid_in = {en[1] && (src_q1.size() != 0), en[0] && (src_q0.size() != 0)};
    bus.req_data_in  = {h1[DATA_W-1:0], h0[DATA_W-1:0]};
    bus.req_last_in  = {h1[DATA_W], h0[DATA_W]};
    bus.out_ready_in = rdy;
    @(negedge clk);
    acc = bus.req_valid_in & bus.req_ready_out;
    @(posedge clk);
    #1;
    if (acc[0]) void'(src_q0.pop_front());
    if (acc[1]) void'(src_q1.pop_front());
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (src_q0.size() != 0 || src_q1.size() != 0); i++) cycle(2'b11, 1'b1);
    cycle(2'b00, 1'b1);
    cycle(2'b00, 1'b1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.req_valid_in = 2'b11;
    bus.req_data_in  = '0;
    bus.req_last_in  = 2'b00;
    bus.out_ready_in = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid_out), 32'd0);
    check("rst_out_data", 32'(bus.out_data_out), 32'd0);
    check("rst_out_last", 32'(bus.out_last_out), 32'd0);
    check("rst_sel", 32'(bus.sel_out), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready_out), 32'd0);
    check("rst_prio", 32'(bus.dbg_prio), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Both sources streaming: alternate A0/B1.
    for (int i = 0; i < 3; i++) begin
      src_q0.push_back({1'b1, 8'hA0});
      src_q1.push_back({1'b1, 8'hB1});
    end
    for (int i = 0; i < 6; i++) cycle(2'b11, 1'b1);

    // Source 1 alone for three beats, then both valid.
    src_q1.push_back({1'b1, 8'h11});
    src_q1.push_back({1'b1, 8'h12});
    src_q1.push_back({1'b1, 8'h13});
    for (int i = 0; i < 3; i++) cycle(2'b10, 1'b1);
    src_q0.push_back({1'b1, 8'h20});
    src_q1.push_back({1'b1, 8'h14});
    cycle(2'b11, 1'b1);
    cycle(2'b11, 1'b1);

    // Backpressure on a held 0x5C, then release and a bubble.
    src_q0.push_back({1'b1, 8'h5C});
    cycle(2'b01, 1'b1);
    src_q1.push_back({1'b1, 8'h77});
    for (int i = 0; i < 4; i++) cycle(2'b10, 1'b0);
    cycle(2'b10, 1'b1);
    cycle(2'b00, 1'b1);
    cycle(2'b00, 1'b1);

    // Three-beat packet on source 0 against a continuously valid source 1.
    src_q0.push_back({1'b0, 8'hC0});
    src_q0.push_back({1'b0, 8'hC1});
    src_q0.push_back({1'b1, 8'hC2});
    src_q1.push_back({1'b1, 8'hD0});
    src_q1.push_back({1'b1, 8'hD1});
    src_q1.push_back({1'b1, 8'hD2});
    drain();

    // Asynchronous reset between edges while traffic is in flight.
    src_q0.push_back({1'b1, 8'h31});
    src_q0.push_back({1'b1, 8'h32});
    src_q1.push_back({1'b1, 8'h41});
    src_q1.push_back({1'b1, 8'h42});
    cycle(2'b11, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid_out), 32'd0);
    check("async_out_data", 32'(bus.out_data_out), 32'd0);
    check("async_out_last", 32'(bus.out_last_out), 32'd0);
    check("async_sel", 32'(bus.sel_out), 32'd0);
    check("async_req_ready", 32'(bus.req_ready_out), 32'd0);
    check("async_prio", 32'(bus.dbg_prio), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drain();

    // Randomized traffic with random backpressure and packet boundaries.
    for (int i = 0; i < 400; i++) begin
      if (src_q0.size() < 3 && $urandom_range(0, 1) == 1)
        src_q0.push_back({1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
      if (src_q1.size() < 3 && $urandom_range(0, 1) == 1)
        src_q1.push_back({1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
      cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
    end
    src_q0.push_back({1'b1, 8'hFE});
    src_q1.push_back({1'b1, 8'hFF});
    drain();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
